// File: rtl/regfile_bist.sv
// regfile_bist: built-in self-test initiator for a 32x32 register file.
// Each run writes all 32 words with a pattern and reads them back as 16
// even/odd pairs, once with the true pattern and once inverted. It reports
// pass/fail, a saturating error count and the first failing address.
module regfile_bist #(
  parameter logic [31:0] BASE           = 32'hA5A5_5A5A,
  parameter bit          ZERO_HARDWIRED = 1'b1
) (
  input  logic        clock_in,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [5:0]  err_count,
  output logic [4:0]  fail_addr,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData,
  output logic        regWrite,
  output logic [4:0]  readReg1,
  output logic [4:0]  readReg2,
  input  logic [31:0] readData1,
  input  logic [31:0] readData2
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0] state;
  logic       pass_idx;
  logic       seen;       // a mismatch has already been recorded this run
  logic       mis1;
  logic       mis2;
  logic [6:0] err_sum;
  logic [5:0] err_next;

  function automatic logic [31:0] pattern(input logic [4:0] a, input logic p);
    return (p ? ~BASE : BASE) ^ {a, a, a, a, a, a, 2'b00};
  endfunction

  function automatic logic [31:0] exp_word(input logic [4:0] a, input logic p);
    if (ZERO_HARDWIRED && a == 5'd0) return '0;
    return pattern(a, p);
  endfunction

  // Compare the pair currently presented and form the saturated count.
  always_comb begin
    mis1     = (readData1 != exp_word(readReg1, pass_idx));
    mis2     = (readData2 != exp_word(readReg2, pass_idx));
    err_sum  = {1'b0, err_count} + {6'd0, mis1} + {6'd0, mis2};
    err_next = (err_sum > 7'd63) ? 6'd63 : err_sum[5:0];
  end

  // Sequencer: write sweep, paired read-back/compare, two passes, result.
  always_ff @(posedge clock_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pass_idx  <= 1'b0;
      seen      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      writeReg  <= '0;
      writeData <= '0;
      regWrite  <= 1'b0;
      readReg1  <= '0;
      readReg2  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_WRITE;
            pass_idx  <= 1'b0;
            seen      <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            regWrite  <= 1'b1;
            writeReg  <= '0;
            writeData <= pattern(5'd0, 1'b0);
          end
        end
        S_WRITE: begin
          if (writeReg == 5'd31) begin
            state     <= S_READ;
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
            readReg1  <= 5'd0;
            readReg2  <= 5'd1;
          end else begin
            writeReg  <= writeReg + 5'd1;
            writeData <= pattern(writeReg + 5'd1, pass_idx);
          end
        end
        S_READ: begin
          err_count <= err_next;
          // Even port is checked first so it wins when both ports fail.
          if (!seen && (mis1 || mis2)) begin
            seen      <= 1'b1;
            fail_addr <= mis1 ? readReg1 : readReg2;
          end
          if (readReg1 == 5'd30) begin
            readReg1 <= '0;
            readReg2 <= '0;
            if (!pass_idx) begin
              state     <= S_WRITE;
              pass_idx  <= 1'b1;
              regWrite  <= 1'b1;
              writeReg  <= '0;
              writeData <= pattern(5'd0, 1'b1);
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 6'd0);
            end
          end else begin
            readReg1 <= readReg1 + 5'd2;
            readReg2 <= readReg2 + 5'd2;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_bist.sv
// Self-checking bench for regfile_bist: a behavioural register file with
// injectable stuck bits, directed scenarios and randomized fault sets.
module tb_regfile_bist;

  localparam logic [31:0] BASE_T = 32'hA5A5_5A5A;

  logic        clock_in = 1'b0;
  logic        rst_n    = 1'b0;
  logic        start    = 1'b0;
  logic        busy, done, pass, regWrite;
  logic [5:0]  err_count;
  logic [4:0]  fail_addr, writeReg, readReg1, readReg2;
  logic [31:0] writeData, readData1, readData2;

  logic [31:0] mem      [32];
  logic [31:0] and_mask [32];
  logic [31:0] or_mask  [32];
  bit          hw0      = 1'b1;
  bit          all_ones = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_bist #(.BASE(BASE_T), .ZERO_HARDWIRED(1'b1)) dut (
    .clock_in (clock_in),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .fail_addr(fail_addr),
    .writeReg (writeReg),
    .writeData(writeData),
    .regWrite (regWrite),
    .readReg1 (readReg1),
    .readReg2 (readReg2),
    .readData1(readData1),
    .readData2(readData2)
  );

  always #5 clock_in = ~clock_in;

  // Register file model with stuck-at masks applied on write.
  always @(posedge clock_in)
    if (regWrite) mem[writeReg] <= (writeData & and_mask[writeReg]) | or_mask[writeReg];

  assign readData1 = all_ones ? '1 : ((hw0 && readReg1 == 5'd0) ? '0 : mem[readReg1]);
  assign readData2 = all_ones ? '1 : ((hw0 && readReg2 == 5'd0) ? '0 : mem[readReg2]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pattern: base (or inverted base) XOR the address replicated into six
  // 5-bit fields above bit 2, i.e. a multiple of 0x08421084.
  function automatic logic [31:0] d_fn(input int a, input int p);
    logic [31:0] b;
    b = (p != 0) ? ~BASE_T : BASE_T;
    return b ^ (32'(a) * 32'h0842_1084);
  endfunction

  task automatic clear_faults();
    for (int i = 0; i < 32; i++) begin
      and_mask[i] = '1;
      or_mask[i]  = '0;
    end
    hw0      = 1'b1;
    all_ones = 1'b0;
  endtask

  // Expected result of one run from the fault model, walking the reads in order.
  task automatic ref_model(output int e, output int f);
    bit seen;
    logic [31:0] stored, rd, ex;
    seen = 0; e = 0; f = 0;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 32; a++) begin
        stored = (d_fn(a, p) & and_mask[a]) | or_mask[a];
        rd = all_ones ? 32'hFFFF_FFFF : ((hw0 && a == 0) ? 32'h0 : stored);
        ex = (a == 0) ? 32'h0 : d_fn(a, p);
        if (rd != ex) begin
          if (!seen) begin f = a; seen = 1; end
          if (e < 63) e++;
        end
      end
  endtask

  task automatic run_once(input string tag, input int ignore_at, input int exp_err, input int exp_fail);
    int lat, wr_bad, rd_bad, p, k;
    wr_bad = 0; rd_bad = 0;
    @(negedge clock_in); start = 1'b1;
    @(posedge clock_in); #1; start = 1'b0;
    lat = 0;
    check({tag, ".start_busy"}, {31'd0, busy}, 32'd1);
    check({tag, ".start_done"}, {31'd0, done}, 32'd0);
    check({tag, ".start_err"}, {26'd0, err_count}, 32'd0);
    while (!done && lat < 200) begin
      start = (ignore_at > 0 && lat == ignore_at - 1);
      if (lat < 96) begin
        p = lat / 48;
        k = lat % 48;
        if (k < 32) begin
          if (!regWrite || writeReg != 5'(k) || writeData != d_fn(k, p)) wr_bad++;
        end else begin
          if (regWrite || writeReg != 5'd0 || writeData != 32'd0 ||
              readReg1 != 5'(2 * (k - 32)) || readReg2 != 5'(2 * (k - 32) + 1)) rd_bad++;
        end
      end
      @(posedge clock_in); #1; lat++;
    end
    start = 1'b0;
    check({tag, ".write_seq"}, wr_bad, 0);
    check({tag, ".read_seq"}, rd_bad, 0);
    check({tag, ".latency"}, lat, 96);
    check({tag, ".done"}, {31'd0, done}, 32'd1);
    check({tag, ".busy"}, {31'd0, busy}, 32'd0);
    check({tag, ".err_count"}, {26'd0, err_count}, exp_err);
    check({tag, ".fail_addr"}, {27'd0, fail_addr}, exp_fail);
    check({tag, ".pass"}, {31'd0, pass}, (exp_err == 0) ? 32'd1 : 32'd0);
    check({tag, ".idle_out"}, {regWrite, writeReg, readReg1, readReg2, writeData[15:0]}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".flags"}, {28'd0, busy, done, pass, regWrite}, 32'd0);
    check({tag, ".counts"}, {16'd0, err_count, fail_addr, writeReg}, 32'd0);
    check({tag, ".rd_addr"}, {22'd0, readReg1, readReg2}, 32'd0);
    check({tag, ".wdata"}, writeData, 32'd0);
  endtask

  initial begin
    int e, f, nf, r, b;
    clear_faults();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    #12;
    check_all_zero("reset");
    @(negedge clock_in); rst_n = 1'b1;
    repeat (2) @(posedge clock_in);
    #1;
    check_all_zero("idle");

    run_once("good", 0, 0, 0);
    repeat (4) @(posedge clock_in);
    #1;
    check("done_hold", {31'd0, done}, 32'd1);
    run_once("repeat", 0, 0, 0);

    clear_faults();
    and_mask[5][0] = 1'b0;
    run_once("stuck5", 0, 1, 5);

    clear_faults();
    hw0 = 1'b0;
    run_once("no_hw0", 0, 2, 0);

    clear_faults();
    all_ones = 1'b1;
    run_once("ones", 0, 63, 0);

    clear_faults();
    run_once("ignore", 40, 0, 0);

    // Reset between E20 and E21 of a run.
    @(negedge clock_in); start = 1'b1;
    @(posedge clock_in); #1; start = 1'b0;
    repeat (20) @(posedge clock_in);
    #1; rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clock_in); rst_n = 1'b1;
    run_once("after_rst", 0, 0, 0);

    for (int it = 0; it < 6; it++) begin
      clear_faults();
      hw0 = ($urandom_range(0, 3) != 0);
      nf  = $urandom_range(0, 3);
      for (int j = 0; j < nf; j++) begin
        r = $urandom_range(0, 31);
        b = $urandom_range(0, 31);
        if ($urandom_range(0, 1) != 0) and_mask[r][b] = 1'b0;
        else or_mask[r][b] = 1'b1;
      end
      ref_model(e, f);
      run_once($sformatf("rand%0d", it), 0, e, f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_bist.md
# regfile_bist

Built-in self-test initiator for the 32×32 register file. It drives the write port (writeReg/writeData/regWrite) and both read ports (readReg1/readReg2), and checks readData1/readData2 against a deterministic pattern. Each run makes two passes, true and inverted, and reports pass/fail, an error count and the first failing address. It sits beside the register file in the lab datapath, and its outputs are muxed onto the register-file ports while busy is high.

## Interface
- BASE, 32'hA5A5_5A5A, base data pattern.
- ZERO_HARDWIRED, 1, when 1, register 0 is expected to read 32'h0 in both passes.

- clock_in  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle request to begin a run; sampled in IDLE or DONE only
- busy  output  1  high while a run is in progress
- done  output  1  high from end of run until the next accepted start
- pass  output  1  done && err_count==0
- err_count  output  6  number of mismatching words, saturates at 63
- fail_addr  output  5  address of the first mismatch; 0 if none
- writeReg  output  5  register-file write address
- writeData  output  32  register-file write data
- regWrite  output  1  register-file write enable
- readReg1  output  5  read address, port 1 (even addresses)
- readReg2  output  5  read address, port 2 (odd addresses)
- readData1  input  32  read data, port 1; combinational from readReg1
- readData2  input  32  read data, port 2; combinational from readReg2

## Operation
- States:
  - IDLE → WRITE on start.
  - WRITE → READ after 32 writes.
  - READ → WRITE with the inverted pass after 16 reads in pass 0.
  - READ → DONE after 16 reads in pass 1.
  - DONE → WRITE on start.
- Data function: D(a,p) = (p ? ~BASE : BASE) ^ {a,a,a,a,a,a,2'b00}, where a is the 5-bit address and p is the pass index (0/1).
- Expected value: E(a,p) = 0 when a==0 and ZERO_HARDWIRED==1; otherwise E(a,p) = D(a,p).
- WRITE: regWrite=1, writeReg=a, writeData=D(a,p), for a=0..31, one address per cycle.
  - Address 0 is written regardless of ZERO_HARDWIRED.
- READ: regWrite=0, writeReg=0, writeData=0. Pair k=0..15 is issued as readReg1=2k, readReg2=2k+1.
  - Both read-data ports are sampled at the edge that ends the cycle the pair is presented.
  - Each port is compared independently against its expected value.
- Error accounting:
  - Each mismatching port adds 1 to err_count, so a pair can add 2.
  - err_count saturates at 63.
  - fail_addr captures the address of the first mismatch of the run. If both ports of that first pair mismatch, the even address wins.
- Start handling:
  - start while busy is ignored.
  - An accepted start clears err_count, fail_addr and done, and sets busy.
- Outputs in IDLE and DONE: readReg1=readReg2=writeReg=0, writeData=0, regWrite=0.

## Timing
- Reset (asynchronous, immediate): state=IDLE; busy, done, pass, regWrite = 0; err_count, fail_addr, writeReg, writeData, readReg1, readReg2 = 0.
  - Reset mid-run aborts the run with no partial result.
  - The register-file contents are left as-is.
- All outputs are registered on the rising edge of clock_in.
- Edge E0 samples start: busy=1, regWrite=1, writeReg=0, writeData=D(0,0).
- Pass 0 write phase:
  - E1..E31 present addresses 1..31.
  - The register file commits each write at the edge following its presentation.
- Pass 0 read phase:
  - E32: regWrite=0, pair 0 presented.
  - Pair k is presented at E32+k and compared at E33+k.
  - Pair 15 is compared at E48.
- E48: pass 1 begins, with writeReg=0 and writeData=D(0,1).
- Pass 1 timeline: writes at E48..E79, pairs presented at E80..E95, last compare at E96.
- E96: busy=0, done=1, and pass/err_count/fail_addr are final, including the compare made at E96.
  - Start-to-done latency is 96 cycles.
- err_count and fail_addr update at the compare edge and are visible mid-run.

## Test plan
- Fault-free register-file model with ZERO_HARDWIRED=1 and $0 hardwired, start pulsed at E0:
  - Write sequence observed: writeReg 0..31, writeData[31:0] at a=1 is 32'hA5A5_5A5A^32'h0842_1084.
  - done rises at E96; pass=1, err_count=0, fail_addr=0.
- Model with register 5 bit 0 stuck at 0:
  - Pass 0 is clean, because D bit0 is 0.
  - Pass 1 mismatches at address 5, so err_count=1, fail_addr=5, pass=0.
- Model with no hardwired $0 and ZERO_HARDWIRED=1:
  - Address 0 reads D(0,p) instead of 0, so err_count=2, fail_addr=0.
- rst_n driven low between E20 and E21:
  - All outputs go to 0 immediately, including regWrite.
  - A new start afterwards completes in 96 cycles with pass=1.
- start pulsed again at E40:
  - Ignored; done still rises at E96.
- start at E100, after done:
  - done clears at E100 and the run repeats, with done at E196.
- Model returning all-ones on both ports:
  - err_count saturates at 63 (64 mismatches); fail_addr=0.
